// File: rtl/corelet_seq_ctrl.sv
// Corelet sequencer: W load, ACT stream, drain, OFIFO write-back.
// Optional `SEQ_TIMEOUT_EN: abort write-back after 256 idle cycles.
module corelet_seq_ctrl #(
  parameter int ROW      = 8,
  parameter int COL      = 8,
  parameter int OP_DEPTH = 340
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       seq_begin,
  input  logic [6:0] cfg_act_len,
  input  logic [8:0] cfg_op_base,
  output logic [6:0] W_addr,
  output logic       W_cen,
  output logic       W_wen,
  output logic [6:0] ACT_addr,
  output logic       ACT_cen,
  output logic       ACT_wen,
  output logic [8:0] OP_addr,
  output logic       OP_cen,
  output logic       OP_wen,
  input  logic       l0_full,
  output logic       l0_wr,
  output logic       load_w,
  output logic       execute,
  input  logic       ofifo_valid,
  output logic       ofifo_rd,
  output logic       busy,
  output logic       seq_done,
  output logic       seq_err
);

  localparam int CW = $clog2(ROW + COL + 130);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WLOAD,
    S_ACT,
    S_DRAIN,
    S_WB,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_len_ext;
  logic [6:0]    r_len;
  logic [8:0]    r_wb_addr;
  logic          r_l0_wr;
  logic          r_wr_w;
  logic          w_w_rd;
  logic          w_a_rd;
  logic          w_op_wr;
  logic          w_start;
  logic          w_tmo;

`ifdef SEQ_TIMEOUT_EN
  logic [7:0]    r_tmo;
  logic          r_err;
`endif

  assign w_len_ext = CW'(r_len);

  // next state, counter update and read/write issue decisions
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_w_rd      = 1'b0;
    w_a_rd      = 1'b0;
    w_op_wr     = 1'b0;
    w_start     = 1'b0;
    w_tmo       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (seq_begin) begin
          w_start     = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_WLOAD;
        end
      end
      S_WLOAD: begin
        if (!l0_full) begin
          w_w_rd = 1'b1;
          if (r_cnt == CW'(ROW - 1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_ACT;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      S_ACT: begin
        if (r_len == 7'd0) begin
          w_state_nxt = S_DRAIN;
        end else if (!l0_full) begin
          w_a_rd = 1'b1;
          if (r_cnt == w_len_ext - CW'(1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_DRAIN;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (r_cnt == CW'(ROW + COL - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_WB;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_WB: begin
        if (r_cnt == w_len_ext) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_DONE;
        end else if (ofifo_valid) begin
          w_op_wr   = 1'b1;
          w_cnt_nxt = r_cnt + CW'(1);
        end
`ifdef SEQ_TIMEOUT_EN
        else if (r_tmo == 8'hFF) begin
          w_tmo       = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_DONE;
        end
`endif
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // counters, latched config and one-cycle read-return strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_len     <= '0;
      r_wb_addr <= '0;
      r_l0_wr   <= 1'b0;
      r_wr_w    <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_l0_wr <= w_w_rd | w_a_rd;
      r_wr_w  <= w_w_rd;
      if (w_start) begin
        r_len     <= cfg_act_len;
        r_wb_addr <= cfg_op_base;
      end else if (w_op_wr) begin
        if (r_wb_addr == 9'(OP_DEPTH - 1)) r_wb_addr <= '0;
        else                               r_wb_addr <= r_wb_addr + 9'd1;
      end
    end
  end

`ifdef SEQ_TIMEOUT_EN
  // idle-cycle counter for write-back and sticky abort flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tmo <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state != S_WB || ofifo_valid) r_tmo <= '0;
      else                                r_tmo <= r_tmo + 8'd1;
      if (w_start)    r_err <= 1'b0;
      else if (w_tmo) r_err <= 1'b1;
    end
  end
  assign seq_err = r_err;
`else
  assign seq_err = 1'b0;
`endif

  assign W_cen    = ~w_w_rd;
  assign W_wen    = 1'b1;
  assign W_addr   = w_w_rd ? r_cnt[6:0] : '0;
  assign ACT_cen  = ~w_a_rd;
  assign ACT_wen  = 1'b1;
  assign ACT_addr = w_a_rd ? r_cnt[6:0] : '0;
  assign OP_cen   = ~w_op_wr;
  assign OP_wen   = ~w_op_wr;
  assign OP_addr  = w_op_wr ? r_wb_addr : '0;
  assign ofifo_rd = w_op_wr;
  assign l0_wr    = r_l0_wr;
  assign load_w   = (r_state == S_WLOAD) | r_wr_w;
  assign execute  = (r_state == S_ACT) | (r_state == S_DRAIN);
  assign busy     = (r_state != S_IDLE);
  assign seq_done = (r_state == S_DONE);

endmodule
